pwm_duty_sequencer: RTL
=======================

# pwm_duty_sequencer

Soft-ramp controller for the 4-bit `PWM` block. It accepts a target duty over a valid/ready handshake and drives the PWM `i_duty` input. The duty moves one LSB at a time toward the target, once every N PWM periods. Duty changes only on PWM period boundaries, so no output period is ever truncated or glitched.

## Interface
Parameters:
- `DUTY_W`, 4, duty width; must match the PWM counter width.
- `DIV_W`, 8, width of the periods-per-step divider.

Ports:
- `i_clk` in 1: single clock, shared with `PWM`.
- `i_rst` in 1: reset, synchronous and active-high.
- `i_tgt_valid` in 1: new target duty offered.
- `i_tgt_duty` in `DUTY_W`: requested target duty.
- `o_tgt_ready` out 1: target can be accepted; high only in S_IDLE.
- `i_step_div` in `DIV_W`: PWM periods per one-LSB step. 0 is treated as 1. Latched on accept.
- `i_period_end` in 1: one-cycle pulse in the last cycle of each PWM period (PWM counter == 2^DUTY_W-1).
- `i_abort` in 1: stop the ramp and freeze the current duty.
- `o_duty` out `DUTY_W`: registered duty; connects to `PWM.i_duty`.
- `o_busy` out 1: ramp in progress.
- `o_done` out 1: one-cycle pulse when `o_duty` reaches the target.

## Operation
- FSM states: S_IDLE, S_RAMP_UP, S_RAMP_DN.
- **Accept:** a transfer occurs when `i_tgt_valid && o_tgt_ready`.
  - The block latches the target and div_eff = max(`i_step_div`, 1), and clears the period count.
  - target > `o_duty` → S_RAMP_UP.
  - target < `o_duty` → S_RAMP_DN.
  - target == `o_duty` → stays in S_IDLE; `o_done` pulses on the next cycle.
- **Ramp:** a `DIV_W`-bit period count increments on each `i_period_end`.
  - Step condition: `i_period_end` and count == div_eff-1.
  - On a step, `o_duty` changes by ±1 and the count clears.
  - If the stepped value equals the target, the FSM goes to S_IDLE and `o_done` is asserted on the same cycle the final `o_duty` value first appears.
- **Arithmetic:** `o_duty` never wraps. It moves only toward the target, so it stays within 0..2^DUTY_W-1.
- **Abort:** `i_abort` in a ramp state → S_IDLE next cycle.
  - `o_duty` holds its current value.
  - No `o_done` pulse.
  - The period count clears.
  - `i_abort` in S_IDLE is ignored.
- **Abort vs. step:** if `i_abort` and a step condition occur on the same cycle, abort wins and the step is not applied.
- `o_busy` = state != S_IDLE.
- `i_tgt_valid` while not ready is ignored; the requester must hold it until accepted.

## Timing
- **Reset values:**
  - state S_IDLE
  - `o_duty` = 0
  - `o_tgt_ready` = 1
  - `o_busy` = 0
  - `o_done` = 0
  - period count = 0
- Reset mid-ramp returns to these values on the next edge; the latched target is discarded.
- **Accept latency:** `o_busy` rises the cycle after the accept edge.
- **Period-end counting:** an `i_period_end` on the accept cycle is not counted. Counting starts the cycle after.
- **Step latency:** `o_duty` updates on the edge that samples the qualifying `i_period_end`, so the new value is valid from the first cycle of the next PWM period.
- **Total ramp time:** |target − start| × div_eff PWM periods.
- **Next target:** `o_tgt_ready` returns high the cycle `o_done` is high. A new target may be accepted in that same cycle.
- **Throughput:** at most one step per PWM period.

## Structure
- Shared package `pwm_pkg`:
  - `DUTY_W_DEF`, `DIV_W_DEF`.
  - `typedef enum logic [1:0] {S_IDLE, S_RAMP_UP, S_RAMP_DN} seq_state_t`.
- Sub-module `pwm_step_timer`: the period count and div_eff compare.
  - Inputs: `clr`, `i_period_end`, `div_eff`.
  - Output: one-cycle `step` pulse.
- The top level holds the FSM, target register, and `o_duty` register.
- Top-level bench instantiates `PWM` driven by `o_duty`, with `i_period_end` derived from the PWM counter.

## Test plan
- **Ramp up:** reset, then accept target 4 with div 1 from duty 0 → `o_duty` steps 1,2,3,4 on four consecutive period ends; `o_done` pulses once with `o_duty`=4; `o_busy` falls the same cycle.
- **Ramp down:** from duty 12, accept target 8 with div 3 → one step every 3 period ends; duty 8 is reached after 12 periods; `o_done` pulses once.
- **Equal target and div 0:** accept target 0 when duty is 0 → `o_done` pulse next cycle, `o_busy` stays low. Separately, div 0 with target 1 → step on the first period end.
- **Abort:** accept 0→15 with div 1, assert `i_abort` after 5 steps, on a cycle that coincides with a qualifying period end → `o_duty` stays 5, no `o_done`, ready high; a later target 15 resumes from 5.
- **Handshake and reset:** hold `i_tgt_valid` with target 2 mid-ramp → not accepted until S_IDLE, then taken in the `o_done` cycle. Assert `i_rst` mid-ramp at duty 7 → `o_duty`=0 and ready=1 on the next edge.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and default widths for the PWM duty sequencer.
package pwm_pkg;

  localparam int DUTY_W_DEF = 4;
  localparam int DIV_W_DEF  = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RAMP_UP,
    S_RAMP_DN
  } seq_state_t;

endpackage : pwm_pkg

// File: rtl/pwm_duty_sequencer_if.sv
// Target-duty request channel: valid/ready handshake carrying the target
// duty and the periods-per-step divider.
interface pwm_duty_sequencer_if #(
  parameter int DUTY_W = 4,
  parameter int DIV_W  = 8
);

  logic              i_tgt_valid;
  logic [DUTY_W-1:0] i_tgt_duty;
  logic [DIV_W-1:0]  i_step_div;
  logic              o_tgt_ready;

  // Requester side: offers a target and holds it until ready.
  modport master (
    output i_tgt_valid,
    output i_tgt_duty,
    output i_step_div,
    input  o_tgt_ready
  );

  // Sequencer side: accepts a target when idle.
  modport slave (
    input  i_tgt_valid,
    input  i_tgt_duty,
    input  i_step_div,
    output o_tgt_ready
  );

endinterface : pwm_duty_sequencer_if

// File: rtl/pwm_step_timer.sv
// Counts PWM period ends and emits a one-cycle step pulse every div_eff
// periods. A clear (idle, abort, accept) restarts the count from zero and
// suppresses any step on that cycle.
module pwm_step_timer
  import pwm_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             clr,
  input  logic             i_period_end,
  input  logic [DIV_W-1:0] div_eff,
  output logic             step
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic             hit;

  // Next count and step qualification.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    cnt_d = cnt_q;
    hit   = (cnt_q == (div_eff - DIV_W'(1)));
    step  = i_period_end && hit && !clr;
    if (clr) begin
      cnt_d = '0;
    end else if (i_period_end) begin
      cnt_d = hit ? '0 : cnt_q + DIV_W'(1);
    end
  end

  // Period count register.
  always_ff @(posedge i_clk) begin
    // NOTE: reset is synchronous (sampled on the clock edge), and state is
    // updated with non-blocking assignments so all flops see pre-edge values.
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : pwm_step_timer

// File: rtl/pwm_duty_sequencer.sv
// Soft-ramp controller for the PWM block: accepts a target duty and walks
// o_duty toward it one LSB per div_eff PWM periods. Duty only changes on
// the edge that samples a period end, so every PWM period is complete.
module pwm_duty_sequencer
  import pwm_pkg::*;
#(
  parameter int DUTY_W = DUTY_W_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  pwm_duty_sequencer_if.slave  tgt_if,
  input  logic                 i_period_end,
  input  logic                 i_abort,
  output logic [DUTY_W-1:0]    o_duty,
  output logic                 o_busy,
  output logic                 o_done
);

  seq_state_t        state_q;
  logic [DUTY_W-1:0] duty_q;
  logic [DUTY_W-1:0] tgt_q;
  logic [DIV_W-1:0]  div_q;
  logic              done_q;

  logic              accept;
  logic              step;
  logic              timer_clr;
  logic [DIV_W-1:0]  div_in_eff;
  logic [DUTY_W-1:0] duty_inc;
  logic [DUTY_W-1:0] duty_dec;

  // A divider of zero behaves as one step per period.
  assign div_in_eff = (tgt_if.i_step_div == '0) ? DIV_W'(1) : tgt_if.i_step_div;
  assign accept     = tgt_if.i_tgt_valid && (state_q == S_IDLE);
  assign duty_inc   = duty_q + DUTY_W'(1);
  assign duty_dec   = duty_q - DUTY_W'(1);

  // The count only runs while ramping; the accept cycle is idle, so a period
  // end coinciding with accept is not counted. Abort also clears it.
  assign timer_clr  = (state_q == S_IDLE) || i_abort;

  pwm_step_timer #(
    .DIV_W (DIV_W)
  ) u_step_timer (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .clr          (timer_clr),
    .i_period_end (i_period_end),
    .div_eff      (div_q),
    .step         (step)
  );

  // Sequencer FSM with target, divider, duty and done registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      duty_q  <= '0;
      tgt_q   <= '0;
      div_q   <= DIV_W'(1);
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            tgt_q <= tgt_if.i_tgt_duty;
            div_q <= div_in_eff;
            if (tgt_if.i_tgt_duty > duty_q) begin
              state_q <= S_RAMP_UP;
            end else if (tgt_if.i_tgt_duty < duty_q) begin
              state_q <= S_RAMP_DN;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        // duty_q < tgt_q here, so the increment cannot wrap.
        S_RAMP_UP: begin
          if (i_abort) begin
            state_q <= S_IDLE;
          end else if (step) begin
            duty_q <= duty_inc;
            if (duty_inc == tgt_q) begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        // duty_q > tgt_q here, so the decrement cannot wrap.
        S_RAMP_DN: begin
          if (i_abort) begin
            state_q <= S_IDLE;
          end else if (step) begin
            duty_q <= duty_dec;
            if (duty_dec == tgt_q) begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_duty             = duty_q;
  assign o_done             = done_q;
  assign o_busy             = (state_q != S_IDLE);
  assign tgt_if.o_tgt_ready = (state_q == S_IDLE);

endmodule : pwm_duty_sequencer
